regfile_scoreboard: RTL

Parametrised integer register file with N combinational read ports, one write-back port, same-cycle write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard. It sits between decode and write-back in the RISC-V pipeline. Decode reads operands and marks destinations busy on issue. Write-back writes results and clears busy. The busy outputs drive the decode stall logic.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rf_read_port.sv | 29 ++
 rtl/regfile_scoreboard.sv | 78 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the integer register file and its busy scoreboard.
package regfile_pkg;

    localparam int XLEN_DEF  = 64;
    localparam int NREGS_DEF = 32;
    localparam int NRD_DEF   = 2;
    localparam int ZERO_REG  = 0;

    function automatic int calc_aw(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: r0 forcing, write-back bypass, array mux and stall term.
module rf_read_port
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic [AW-1:0]                sr,
    input  logic                         wb_ld_reg,
    input  logic [AW-1:0]                wb_dr,
    input  logic [XLEN-1:0]              wb_data,
    input  logic [NREGS-1:0][XLEN-1:0]   regs,
    input  logic [NREGS-1:0]             busy,
    output logic [XLEN-1:0]              rd_data,
    output logic                         rd_busy
);

    logic is_zero;
    logic wb_hit;

    assign is_zero = (sr == AW'(ZERO_REG));
    assign wb_hit  = wb_ld_reg && (wb_dr == sr);

    // A completing write-back satisfies the read this cycle, so it neither stalls nor reads stale data.
    assign rd_data = is_zero ? '0 : (wb_hit ? wb_data : regs[sr]);
    assign rd_busy = busy[sr] && !wb_hit;

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with hardwired r0, write-back bypass and a per-register busy scoreboard
// used by decode to stall on operands with pending producers.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int XLEN  = XLEN_DEF,
    parameter  int NREGS = NREGS_DEF,
    parameter  int NRD   = NRD_DEF,
    localparam int AW    = calc_aw(NREGS)
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic [NRD*AW-1:0]    SR,
    output logic [NRD*XLEN-1:0]  RD_DATA,
    output logic [NRD-1:0]       RD_BUSY,
    input  logic                 WB_LD_REG,
    input  logic [AW-1:0]        WB_DR,
    input  logic [XLEN-1:0]      WB_DATA,
    input  logic                 ISSUE_V,
    input  logic [AW-1:0]        ISSUE_DR,
    input  logic                 FLUSH,
    output logic                 ANY_BUSY
);

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           busy_next;
    logic                       wb_we;
    logic                       issue_we;

    assign wb_we    = WB_LD_REG && (WB_DR    != AW'(ZERO_REG));
    assign issue_we = ISSUE_V   && (ISSUE_DR != AW'(ZERO_REG));

    // Issue is applied after write-back so the newer producer keeps the register busy.
    always_comb begin
        // NOTE: full default first so no path leaves busy_next unassigned (no latch).
        busy_next = busy;
        if (FLUSH) begin
            busy_next = '0;
        end else begin
            if (wb_we)
                busy_next[WB_DR] = 1'b0;
            if (issue_we)
                busy_next[ISSUE_DR] = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            // NOTE: the data array is reset too, since reads must return 0 straight out of reset.
            regs <= '0;
            busy <= '0;
        end else begin
            if (wb_we)
                regs[WB_DR] <= WB_DATA;
            busy <= busy_next;
        end
    end

    assign ANY_BUSY = |busy;

    for (genvar i = 0; i < NRD; i++) begin : g_port
        rf_read_port #(
            .XLEN  (XLEN),
            .NREGS (NREGS)
        ) u_port (
            .sr        (SR[i*AW +: AW]),
            .wb_ld_reg (WB_LD_REG),
            .wb_dr     (WB_DR),
            .wb_data   (WB_DATA),
            .regs      (regs),
            .busy      (busy),
            .rd_data   (RD_DATA[i*XLEN +: XLEN]),
            .rd_busy   (RD_BUSY[i])
        );
    end

endmodule
